// File: rtl/snake_body.sv
// Snake body store and move sequencer: scans the body one segment per cycle for
// a self-collision, checks walls and food, then shifts the body or enters DEAD.
module snake_body #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int GRID_X   = 64,
    parameter int GRID_Y   = 64,
    parameter int INIT_X   = 32,
    parameter int INIT_Y   = 32
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Start,
    input  logic                       i_Tick,
    input  logic [6:0]                 i_Next_x,
    input  logic [6:0]                 i_Next_y,
    input  logic [1:0]                 i_Next_Way,
    input  logic [6:0]                 i_Food_x,
    input  logic [6:0]                 i_Food_y,
    input  logic [$clog2(MAX_LEN)-1:0] i_Rd_idx,
    output logic [6:0]                 o_Head_x,
    output logic [6:0]                 o_Head_y,
    output logic [1:0]                 o_Way,
    output logic [$clog2(MAX_LEN):0]   o_Len,
    output logic [6:0]                 o_Rd_x,
    output logic [6:0]                 o_Rd_y,
    output logic                       o_Rd_valid,
    output logic                       o_Busy,
    output logic                       o_Eat,
    output logic                       o_Dead
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;
    localparam logic [7:0] GX_L = 8'(GRID_X);
    localparam logic [7:0] GY_L = 8'(GRID_Y);
    localparam logic [1:0] WAY_RIGHT = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CHECK, S_COMMIT, S_DEAD} state_t;

    state_t         state_q;
    logic [6:0]     seg_x_q [MAX_LEN];
    logic [6:0]     seg_y_q [MAX_LEN];
    logic [6:0]     nx_q, ny_q;
    logic [1:0]     nway_q, way_q;
    logic [LW-1:0]  len_q, lim_q;
    logic [IW-1:0]  idx_q;
    logic           grow_q, busy_q, eat_q, dead_q;

    logic [LW-1:0]  len_d, lim_d;
    logic           tick_eat, wall_hit, seg_hit, last_seg;

    assign tick_eat = (i_Next_x == i_Food_x) && (i_Next_y == i_Food_y);
    // Growing moves must also check the tail, since it does not vacate.
    assign lim_d    = tick_eat ? len_q : len_q - 1'b1;
    assign len_d    = (grow_q && (len_q < LW'(MAX_LEN))) ? len_q + 1'b1 : len_q;

    // Wall is evaluated on the first scan cycle only; idx is zero only then.
    assign wall_hit = (idx_q == '0) &&
                      (({1'b0, nx_q} >= GX_L) || ({1'b0, ny_q} >= GY_L));
    assign seg_hit  = (seg_x_q[idx_q] == nx_q) && (seg_y_q[idx_q] == ny_q);
    assign last_seg = ({1'b0, idx_q} == (lim_q - 1'b1));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x_q[k] <= 7'(INIT_X);
                seg_y_q[k] <= (k < INIT_LEN) ? 7'(INIT_Y - k) : 7'd0;
            end
            nx_q   <= '0;
            ny_q   <= '0;
            nway_q <= '0;
            way_q  <= WAY_RIGHT;
            len_q  <= LW'(INIT_LEN);
            lim_q  <= '0;
            idx_q  <= '0;
            grow_q <= 1'b0;
            busy_q <= 1'b0;
            eat_q  <= 1'b0;
            dead_q <= 1'b0;
        end else begin
            eat_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_Start) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (i_Tick) begin
                        nx_q    <= i_Next_x;
                        ny_q    <= i_Next_y;
                        nway_q  <= i_Next_Way;
                        grow_q  <= tick_eat;
                        lim_q   <= lim_d;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (wall_hit || seg_hit) begin
                        dead_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DEAD;
                    end else if (last_seg) begin
                        state_q <= S_COMMIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_COMMIT: begin
                    for (int k = MAX_LEN - 1; k > 0; k--) begin
                        seg_x_q[k] <= seg_x_q[k-1];
                        seg_y_q[k] <= seg_y_q[k-1];
                    end
                    seg_x_q[0] <= nx_q;
                    seg_y_q[0] <= ny_q;
                    way_q      <= nway_q;
                    len_q      <= len_d;
                    eat_q      <= grow_q;
                    busy_q     <= 1'b0;
                    state_q    <= S_RUN;
                end
                S_DEAD: begin
                    if (i_Start) begin
                        for (int k = 0; k < MAX_LEN; k++) begin
                            seg_x_q[k] <= 7'(INIT_X);
                            seg_y_q[k] <= (k < INIT_LEN) ? 7'(INIT_Y - k) : 7'd0;
                        end
                        way_q   <= WAY_RIGHT;
                        len_q   <= LW'(INIT_LEN);
                        dead_q  <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_Head_x   = seg_x_q[0];
    assign o_Head_y   = seg_y_q[0];
    assign o_Way      = way_q;
    assign o_Len      = len_q;
    assign o_Rd_x     = seg_x_q[i_Rd_idx];
    assign o_Rd_y     = seg_y_q[i_Rd_idx];
    assign o_Rd_valid = ({1'b0, i_Rd_idx} < len_q);
    assign o_Busy     = busy_q;
    assign o_Eat      = eat_q;
    assign o_Dead     = dead_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: moves, eating, tail chase, collisions, walls,
// capacity limit and asynchronous reset.
module tb_snake_body;
    logic       i_Clk = 1'b0, i_Rst = 1'b1, i_Start = 1'b0, i_Tick = 1'b0;
    logic [6:0] i_Next_x = '0, i_Next_y = '0, i_Food_x = '0, i_Food_y = '0;
    logic [1:0] i_Next_Way = '0;
    logic [2:0] i_Rd_idx = '0;
    logic [6:0] o_Head_x, o_Head_y, o_Rd_x, o_Rd_y;
    logic [1:0] o_Way;
    logic [3:0] o_Len;
    logic       o_Rd_valid, o_Busy, o_Eat, o_Dead;

    int vec_cnt = 0;
    int err_cnt = 0;

    snake_body #(.MAX_LEN(8), .INIT_LEN(3), .GRID_X(32), .GRID_Y(32),
                 .INIT_X(16), .INIT_Y(16)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Tick(i_Tick),
        .i_Next_x(i_Next_x), .i_Next_y(i_Next_y), .i_Next_Way(i_Next_Way),
        .i_Food_x(i_Food_x), .i_Food_y(i_Food_y), .i_Rd_idx(i_Rd_idx),
        .o_Head_x(o_Head_x), .o_Head_y(o_Head_y), .o_Way(o_Way), .o_Len(o_Len),
        .o_Rd_x(o_Rd_x), .o_Rd_y(o_Rd_y), .o_Rd_valid(o_Rd_valid),
        .o_Busy(o_Busy), .o_Eat(o_Eat), .o_Dead(o_Dead)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [13:0] xy(input int x, input int y);
        return {7'(x), 7'(y)};
    endfunction

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic start_game();
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
    endtask

    // Issues one tick, then counts sampled busy cycles and eat pulses.
    task automatic move(input int x, input int y, input int w, input int fx,
                        input int fy, output int busy_n, output int eat_n);
        i_Next_x = 7'(x); i_Next_y = 7'(y); i_Next_Way = 2'(w);
        i_Food_x = 7'(fx); i_Food_y = 7'(fy);
        i_Tick = 1'b1;
        step();
        i_Tick = 1'b0;
        busy_n = 0;
        eat_n  = 0;
        while (o_Busy && busy_n < 40) begin
            busy_n++;
            step();
            if (o_Eat) eat_n++;
        end
        step();
        if (o_Eat) eat_n++;
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        step(); step();
        i_Rst = 1'b0;
        step();
        if ({o_Head_x, o_Head_y} !== xy(16, 16)) begin err_cnt++; $display("FAIL reset_head: got %0d,%0d want 16,16", o_Head_x, o_Head_y); end vec_cnt++;
        if (o_Way !== 2'd2) begin err_cnt++; $display("FAIL reset_way: got %0d want 2", o_Way); end vec_cnt++;
        if (o_Len !== 4'd3) begin err_cnt++; $display("FAIL reset_len: got %0d want 3", o_Len); end vec_cnt++;
        if ({o_Dead, o_Busy, o_Eat} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags: got %b want 000", {o_Dead, o_Busy, o_Eat}); end vec_cnt++;
        i_Rd_idx = 3'd2; #1;
        if ({o_Rd_valid, o_Rd_x, o_Rd_y} !== {1'b1, xy(16, 14)}) begin err_cnt++; $display("FAIL reset_rd2: got v%0d %0d,%0d want v1 16,14", o_Rd_valid, o_Rd_x, o_Rd_y); end vec_cnt++;
        i_Rd_idx = 3'd3; #1;
        if (o_Rd_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rd3_valid: got %0d want 0", o_Rd_valid); end vec_cnt++;
    endtask

    task automatic test_idle();
        i_Next_x = 7'd16; i_Next_y = 7'd17; i_Next_Way = 2'd2;
        i_Tick = 1'b1;
        step();
        i_Tick = 1'b0;
        step();
        if (o_Busy !== 1'b0) begin err_cnt++; $display("FAIL idle_tick_busy: got %0d want 0", o_Busy); end vec_cnt++;
        i_Start = 1'b1; i_Tick = 1'b1;
        step();
        i_Start = 1'b0; i_Tick = 1'b0;
        step(); step();
        if ({o_Busy, o_Head_x, o_Head_y} !== {1'b0, xy(16, 16)}) begin err_cnt++; $display("FAIL start_tick: got busy%0d %0d,%0d want busy0 16,16", o_Busy, o_Head_x, o_Head_y); end vec_cnt++;
    endtask

    task automatic test_plain_move();
        int b, e;
        move(16, 17, 2, 0, 0, b, e);
        if (b !== 3) begin err_cnt++; $display("FAIL plain_busy: got %0d want 3", b); end vec_cnt++;
        if (e !== 0) begin err_cnt++; $display("FAIL plain_eat: got %0d want 0", e); end vec_cnt++;
        if ({o_Head_x, o_Head_y} !== xy(16, 17)) begin err_cnt++; $display("FAIL plain_head: got %0d,%0d want 16,17", o_Head_x, o_Head_y); end vec_cnt++;
        if (o_Len !== 4'd3) begin err_cnt++; $display("FAIL plain_len: got %0d want 3", o_Len); end vec_cnt++;
        i_Rd_idx = 3'd2; #1;
        if ({o_Rd_x, o_Rd_y} !== xy(16, 15)) begin err_cnt++; $display("FAIL plain_seg2: got %0d,%0d want 16,15", o_Rd_x, o_Rd_y); end vec_cnt++;
    endtask

    task automatic test_eat();
        int b, e;
        move(16, 18, 2, 16, 18, b, e);
        if (b !== 4) begin err_cnt++; $display("FAIL eat_busy: got %0d want 4", b); end vec_cnt++;
        if (e !== 1) begin err_cnt++; $display("FAIL eat_pulse: got %0d want 1", e); end vec_cnt++;
        if (o_Len !== 4'd4) begin err_cnt++; $display("FAIL eat_len: got %0d want 4", o_Len); end vec_cnt++;
        i_Rd_idx = 3'd3; #1;
        if ({o_Rd_valid, o_Rd_x, o_Rd_y} !== {1'b1, xy(16, 15)}) begin err_cnt++; $display("FAIL eat_seg3: got v%0d %0d,%0d want v1 16,15", o_Rd_valid, o_Rd_x, o_Rd_y); end vec_cnt++;
    endtask

    task automatic test_tail_chase();
        int b, e;
        move(17, 18, 1, 0, 0, b, e);
        move(17, 17, 3, 0, 0, b, e);
        move(16, 17, 0, 0, 0, b, e);
        if ({b, 31'(o_Dead)} !== {32'd4, 31'd0}) begin err_cnt++; $display("FAIL chase1: got busy%0d dead%0d want busy4 dead0", b, o_Dead); end vec_cnt++;
        if ({o_Head_x, o_Head_y, o_Way} !== {xy(16, 17), 2'd0}) begin err_cnt++; $display("FAIL chase1_head: got %0d,%0d w%0d want 16,17 w0", o_Head_x, o_Head_y, o_Way); end vec_cnt++;
        move(16, 18, 2, 0, 0, b, e);
        if ({o_Dead, o_Head_x, o_Head_y, o_Len} !== {1'b0, xy(16, 18), 4'd4}) begin err_cnt++; $display("FAIL chase2: got dead%0d %0d,%0d len%0d want dead0 16,18 len4", o_Dead, o_Head_x, o_Head_y, o_Len); end vec_cnt++;
    endtask

    // Food on the tail cell: the tail does not vacate, so this is a collision.
    task automatic test_self_hit();
        int b, e;
        move(17, 18, 1, 17, 18, b, e);
        if (b !== 4) begin err_cnt++; $display("FAIL selfhit_busy: got %0d want 4", b); end vec_cnt++;
        if ({o_Dead, e[0]} !== 2'b10) begin err_cnt++; $display("FAIL selfhit_dead: got dead%0d eat%0d want dead1 eat0", o_Dead, e); end vec_cnt++;
        if ({o_Head_x, o_Head_y, o_Way, o_Len} !== {xy(16, 18), 2'd2, 4'd4}) begin err_cnt++; $display("FAIL selfhit_frozen: got %0d,%0d w%0d len%0d want 16,18 w2 len4", o_Head_x, o_Head_y, o_Way, o_Len); end vec_cnt++;
    endtask

    task automatic test_wall_restart();
        int b, e;
        move(16, 19, 2, 0, 0, b, e);
        if ({b, o_Dead, o_Head_x, o_Head_y} !== {32'd0, 1'b1, xy(16, 18)}) begin err_cnt++; $display("FAIL dead_tick: got busy%0d dead%0d %0d,%0d want busy0 dead1 16,18", b, o_Dead, o_Head_x, o_Head_y); end vec_cnt++;
        start_game();
        i_Rd_idx = 3'd2; #1;
        if ({o_Dead, o_Head_x, o_Head_y, o_Way, o_Len} !== {1'b0, xy(16, 16), 2'd2, 4'd3}) begin err_cnt++; $display("FAIL restart1: got dead%0d %0d,%0d w%0d len%0d want dead0 16,16 w2 len3", o_Dead, o_Head_x, o_Head_y, o_Way, o_Len); end vec_cnt++;
        if ({o_Rd_x, o_Rd_y} !== xy(16, 14)) begin err_cnt++; $display("FAIL restart1_seg2: got %0d,%0d want 16,14", o_Rd_x, o_Rd_y); end vec_cnt++;
        move(127, 16, 0, 0, 0, b, e);
        if ({b, o_Dead, o_Head_x, o_Head_y} !== {32'd1, 1'b1, xy(16, 16)}) begin err_cnt++; $display("FAIL wall_x: got busy%0d dead%0d %0d,%0d want busy1 dead1 16,16", b, o_Dead, o_Head_x, o_Head_y); end vec_cnt++;
        start_game();
        move(15, 16, 0, 0, 0, b, e);
        if ({b, o_Head_x, o_Head_y, o_Way} !== {32'd3, xy(15, 16), 2'd0}) begin err_cnt++; $display("FAIL restart_move: got busy%0d %0d,%0d w%0d want busy3 15,16 w0", b, o_Head_x, o_Head_y, o_Way); end vec_cnt++;
        move(15, 32, 2, 0, 0, b, e);
        if ({b, o_Dead, o_Head_x, o_Head_y} !== {32'd1, 1'b1, xy(15, 16)}) begin err_cnt++; $display("FAIL wall_y: got busy%0d dead%0d %0d,%0d want busy1 dead1 15,16", b, o_Dead, o_Head_x, o_Head_y); end vec_cnt++;
        start_game();
    endtask

    task automatic test_capacity();
        int b, e;
        for (int i = 0; i < 5; i++) begin
            move(16, 17 + i, 2, 16, 17 + i, b, e);
            if ({b, e, 28'(o_Len)} !== {32'(4 + i), 32'd1, 28'(4 + i)}) begin err_cnt++; $display("FAIL grow%0d: got busy%0d eat%0d len%0d want busy%0d eat1 len%0d", i, b, e, o_Len, 4 + i, 4 + i); end vec_cnt++;
        end
        move(16, 22, 2, 16, 22, b, e);
        if ({b, e, 28'(o_Len)} !== {32'd9, 32'd1, 28'd8}) begin err_cnt++; $display("FAIL cap_eat: got busy%0d eat%0d len%0d want busy9 eat1 len8", b, e, o_Len); end vec_cnt++;
        i_Rd_idx = 3'd7; #1;
        if ({o_Rd_valid, o_Rd_x, o_Rd_y} !== {1'b1, xy(16, 15)}) begin err_cnt++; $display("FAIL cap_seg7: got v%0d %0d,%0d want v1 16,15", o_Rd_valid, o_Rd_x, o_Rd_y); end vec_cnt++;
        move(16, 23, 2, 0, 0, b, e);
        if ({b, e, 28'(o_Len)} !== {32'd8, 32'd0, 28'd8}) begin err_cnt++; $display("FAIL cap_move: got busy%0d eat%0d len%0d want busy8 eat0 len8", b, e, o_Len); end vec_cnt++;
        if ({o_Rd_x, o_Rd_y} !== xy(16, 16)) begin err_cnt++; $display("FAIL cap_move_seg7: got %0d,%0d want 16,16", o_Rd_x, o_Rd_y); end vec_cnt++;
    endtask

    task automatic test_mid_reset();
        i_Next_x = 7'd16; i_Next_y = 7'd24; i_Next_Way = 2'd2;
        i_Food_x = 7'd0; i_Food_y = 7'd0;
        i_Tick = 1'b1;
        step();
        i_Tick = 1'b0;
        step();
        if (o_Busy !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy_before: got %0d want 1", o_Busy); end vec_cnt++;
        #2 i_Rst = 1'b1;
        #1;
        if ({o_Head_x, o_Head_y, o_Way, o_Len} !== {xy(16, 16), 2'd2, 4'd3}) begin err_cnt++; $display("FAIL midrst_state: got %0d,%0d w%0d len%0d want 16,16 w2 len3", o_Head_x, o_Head_y, o_Way, o_Len); end vec_cnt++;
        if ({o_Busy, o_Dead, o_Eat} !== 3'b000) begin err_cnt++; $display("FAIL midrst_flags: got %b want 000", {o_Busy, o_Dead, o_Eat}); end vec_cnt++;
        step();
        i_Rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_plain_move();
        test_eat();
        test_tail_chase();
        test_self_hit();
        test_wall_restart();
        test_capacity();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/snake_body.md
# snake_body

Snake body store and move sequencer, directly downstream of the next-head calculator. On each move strobe it takes the proposed head coordinate and direction, scans the current body for a self-collision, checks the walls and food, and then either commits the move or enters the dead state. The committed head and direction feed back into the next-head calculator. A random-access read port serves the renderer.

## Interface
- `MAX_LEN`, default 16: body segment capacity (≥ 4).
- `INIT_LEN`, default 3: length after reset or restart (2 ≤ `INIT_LEN` ≤ `MAX_LEN`).
- `GRID_X`, default 64: row count; a row coordinate ≥ `GRID_X` is a wall hit.
- `GRID_Y`, default 64: column count; a column coordinate ≥ `GRID_Y` is a wall hit.
- `INIT_X`, default 32: initial head row.
- `INIT_Y`, default 32: initial head column (requires `INIT_Y` ≥ `INIT_LEN` − 1).

Ports:
- `i_Clk`, in, 1: the single clock.
- `i_Rst`, in, 1: reset, asynchronous and active-high.
- `i_Start`, in, 1: starts play from IDLE; restarts from DEAD.
- `i_Tick`, in, 1: single-cycle move strobe.
- `i_Next_x`, `i_Next_y`, in, 7 each: proposed head from the next-head calculator.
- `i_Next_Way`, in, 2: proposed direction (0 = UP, 1 = DOWN, 2 = RIGHT, 3 = LEFT).
- `i_Food_x`, `i_Food_y`, in, 7 each: food cell, sampled with `i_Tick`.
- `i_Rd_idx`, in, log2(`MAX_LEN`): renderer segment index (0 = head).
- `o_Head_x`, `o_Head_y`, out, 7 each: committed head, i.e. segment 0.
- `o_Way`, out, 2: committed direction.
- `o_Len`, out, log2(`MAX_LEN`)+1: current length.
- `o_Rd_x`, `o_Rd_y`, out, 7 each: value of segment `i_Rd_idx`, combinational.
- `o_Rd_valid`, out, 1: high when `i_Rd_idx` < `o_Len`.
- `o_Busy`, out, 1: a move is in progress; ticks are ignored while it is high.
- `o_Eat`, out, 1: one-cycle pulse when food is eaten.
- `o_Dead`, out, 1: level, high in DEAD.

## Operation
- Coordinates: x is the row (UP/DOWN change it); y is the column (RIGHT/LEFT change it). An upstream −1 from 0 arrives as 127 and is caught by the wall check.
- Reset and restart contents:
  - Segment k = (`INIT_X`, `INIT_Y` − k) for k < `INIT_LEN`; other segments are don't-care.
  - `o_Way` = 2 (RIGHT), `o_Len` = `INIT_LEN`.
  - `o_Busy` = `o_Eat` = `o_Dead` = 0. State is IDLE.
- States: IDLE, RUN, CHECK, COMMIT, DEAD.
  - IDLE → RUN when `i_Start` = 1. `i_Tick` is ignored in IDLE.
  - RUN, when `i_Tick` = 1:
    - Register the next head, next direction and food into r_Next, r_Way and r_Food.
    - eat = (next == food).
    - lim = `o_Len` if eat, else `o_Len` − 1. The tail cell vacates on a non-growing move, so moving into it is legal.
    - idx ← 0; go to CHECK.
  - CHECK, one segment per cycle:
    - Compare r_Next with segment idx.
    - Also, in the first CHECK cycle only: wall = (r_Next.x ≥ `GRID_X`) or (r_Next.y ≥ `GRID_Y`).
    - Wall hit or segment match → DEAD.
    - Otherwise, if idx == lim − 1 → COMMIT; else idx ← idx + 1.
  - COMMIT:
    - seg[k] ← seg[k−1] for k = 1..`MAX_LEN`−1; seg[0] ← r_Next; `o_Way` ← r_Way.
    - If eat and `o_Len` < `MAX_LEN`: `o_Len` ← `o_Len` + 1. The shifted-in old tail becomes the new last segment.
    - If eat: `o_Eat` = 1 for one cycle. At `MAX_LEN`, eat still pulses but length is unchanged.
    - → RUN.
  - DEAD:
    - Body, `o_Len` and `o_Way` are frozen. `i_Tick` is ignored.
    - `i_Start` reloads the reset contents and goes directly to RUN.
- Read port: combinational from the segment array. During CHECK it shows the pre-move body.

## Timing
- Tick sampled at clock edge E:
  - CHECK occupies lim cycles, then COMMIT occupies 1 cycle.
  - Updated head, direction, length and the `o_Eat` pulse all become visible together, after edge E + lim + 1.
- `o_Busy` is high from the cycle after E through the COMMIT cycle, and falls together with the output update.
- Death at CHECK cycle j (1-based): `o_Dead` rises after edge E + j; `o_Busy` falls at the same time.
- Simultaneous `i_Start` and `i_Tick` in IDLE: only the start takes effect.
- Asserting `i_Rst` at any point, including mid-CHECK, immediately forces all reset values.

## Test plan
Defaults for all scenarios unless stated: `MAX_LEN`=8, `INIT_LEN`=3, `GRID_X`=`GRID_Y`=32, `INIT_X`=`INIT_Y`=16.

- **Reset values.** Release reset → head (16,16), `o_Way`=2, `o_Len`=3, `o_Dead`=0. `i_Rd_idx`=2 gives (16,14) with valid=1; `i_Rd_idx`=3 gives valid=0.
- **Plain move.** Start; tick with next (16,17), direction 2, food (0,0) → `o_Busy` high 3 cycles. Then head (16,17), segment 2 = (16,15), `o_Len`=3, `o_Eat` never high.
- **Eat.** Same tick with food (16,17) → CHECK lasts 3 cycles. `o_Eat` pulses once, `o_Len`=4, segment 3 = (16,14).
- **Tail chase.** Grow to length 4, then drive the head round a 2×2 loop so it enters the cell the tail occupied, without food → no death.
- **Wall hit and restart.** Next (127,16) → `o_Dead`=1 one cycle after the first CHECK cycle; head still (16,16); further ticks ignored. `i_Start` → reset contents restored, state RUN.
- **Capacity limit and mid-move reset.**
  - At `o_Len`=8, eat → `o_Eat` pulses but `o_Len` stays 8.
  - Assert `i_Rst` during CHECK → all outputs return to reset values in the same cycle, asynchronously.
